// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame width and bit-timing derivation,
// so the transmitter and receiver always agree on the same numbers.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Integer division truncates; 25 MHz / 115200 gives 217 clocks per bit.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half_bit(input int clk_freq, input int baud);
        return calc_clks_per_bit(clk_freq, baud) / 2;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, 3-sample majority filter
// at mid-bit, and a one-entry valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                 i_Clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int H            = calc_half_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_EVAL = CNT_W'(H + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 8) begin : g_cfg_check
        $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end

    logic sync1_q, sync2_q, prev_q;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [1:0]           samp_q,  samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q,  ferr_d;
    logic                 ovr_q,   ovr_d;

    logic fall, maj, at_eval, at_last, complete;

    // Synchronizer and edge-detect flops reset to the idle (high) level so that
    // releasing reset never looks like a start edge.
    always_ff @(posedge i_Clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge i_Clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            samp_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign fall    = prev_q & ~sync2_q;
    assign maj     = majority3(samp_q[1], samp_q[0], sync2_q);
    assign at_eval = (cnt_q == CNT_EVAL);
    assign at_last = (cnt_q == CNT_LAST);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        samp_d   = samp_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        complete = 1'b0;

        if (cnt_q == CNT_S0) samp_d[1] = sync2_q;
        if (cnt_q == CNT_S1) samp_d[0] = sync2_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                if (at_eval && maj) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (at_eval) shift_d[idx_q] = maj;
                if (at_last) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_STOP: begin
                // Finish at mid stop bit so a back-to-back start edge is not missed.
                if (at_eval) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (maj) complete = 1'b1;
                    else     ferr_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, overrun, framing error, false start,
// majority filtering, mid-frame reset and +/-2% baud skew.
module tb_uart_rx;

    localparam int CPB = 217;   // 25_000_000 / 115200, truncated
    localparam int H   = 108;   // CPB / 2

    logic       i_Clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_overrun, rx_busy;

    always #20 i_Clk = ~i_Clk;

    uart_rx #(.CLK_FREQ(25_000_000), .BAUD(115200)) dut (
        .i_Clk       (i_Clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stop_cyc = 0;

    logic [7:0] got_q[$];
    int ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, both_cnt = 0;
    int valid_rise_cyc = 0;
    logic valid_prev = 1'b0;

    always @(posedge i_Clk) cyc <= cyc + 1;

    // Observes outputs 2 time units after the falling edge, after inputs settle.
    always begin
        @(negedge i_Clk);
        #2;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_frame_err) ferr_cnt++;
        if (rx_overrun) ovr_cnt++;
        if (rx_frame_err && rx_overrun) both_cnt++;
        if (rx_busy) busy_cnt++;
        if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
        valid_prev = rx_valid;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_byte();
        if (got_q.size() == 0) return 32'hDEAD;
        return {24'd0, got_q.pop_front()};
    endfunction

    task automatic tick();
        @(negedge i_Clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) tick();
    endtask

    // gbit is the frame bit index (0 = start, 1..8 = data, 9 = stop) that gets a
    // one-clock inversion at clock offset gpos; gbit = -1 disables it.
    task automatic send_byte(input logic [7:0] b, input int period, input logic stop_val,
                             input int gbit, input int gpos);
        logic bv;
        for (int f = 0; f < 10; f++) begin
            if (f == 0)      bv = 1'b0;
            else if (f == 9) bv = stop_val;
            else             bv = b[f-1];
            for (int j = 0; j < period; j++) begin
                rx_in = (f == gbit && j == gpos) ? ~bv : bv;
                if (f == 9 && j == 0) stop_cyc = cyc;
                tick();
            end
        end
        rx_in = 1'b1;
    endtask

    int f0, o0, b0, lat;

    initial begin
        repeat (5) tick();
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_busy", rx_busy, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_ovr", rx_overrun, 0);
        rst = 1'b0;
        idle(20);
        check("rst_release_busy", busy_cnt, 0);

        // 0x55 with consumer always ready
        rx_ready = 1'b1;
        got_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_byte(8'h55, CPB, 1'b1, -1, 0);
        idle(50);
        check("t55_count", got_q.size(), 1);
        check("t55_data", pop_byte(), 8'h55);
        check("t55_ferr", ferr_cnt - f0, 0);
        check("t55_ovr", ovr_cnt - o0, 0);
        // Counted from the first clock edge that sees the stop-bit level.
        lat = valid_rise_cyc - stop_cyc - 1;
        check("t55_latency_le_h4", (lat > 0 && lat <= H + 4), 1);

        // Overrun: 0xA3 held, 0x3C dropped
        rx_ready = 1'b0;
        got_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_byte(8'hA3, CPB, 1'b1, -1, 0);
        idle(20);
        check("ovr_valid_a3", rx_valid, 1);
        check("ovr_data_a3", rx_data, 8'hA3);
        send_byte(8'h3C, CPB, 1'b1, -1, 0);
        idle(20);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_ferr", ferr_cnt - f0, 0);
        check("ovr_data_held", rx_data, 8'hA3);
        check("ovr_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        tick();
        tick();
        check("ovr_accept_clear", rx_valid, 0);
        check("ovr_data_after_accept", rx_data, 8'hA3);
        check("ovr_accept_count", got_q.size(), 1);
        check("ovr_accept_data", pop_byte(), 8'hA3);

        // Framing error on 0x81, then good 0x42
        got_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_byte(8'h81, CPB, 1'b0, -1, 0);
        idle(CPB);
        check("ferr_pulse", ferr_cnt - f0, 1);
        check("ferr_no_ovr", ovr_cnt - o0, 0);
        check("ferr_no_byte", got_q.size(), 0);
        check("ferr_valid", rx_valid, 0);
        send_byte(8'h42, CPB, 1'b1, -1, 0);
        idle(50);
        check("ferr_next_count", got_q.size(), 1);
        check("ferr_next_data", pop_byte(), 8'h42);

        // 50-clock low glitch on idle line: false start
        got_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
        rx_in = 1'b0;
        repeat (50) tick();
        idle(300);
        check("glitch_busy_cycles", busy_cnt - b0, H + 2);
        check("glitch_busy_end", rx_busy, 0);
        check("glitch_no_byte", got_q.size(), 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_ovr", ovr_cnt - o0, 0);
        check("glitch_valid", rx_valid, 0);

        // One-clock glitch at sample H of data bit 3 of 0xFF
        got_q.delete();
        send_byte(8'hFF, CPB, 1'b1, 4, H + 1);
        idle(50);
        check("maj_count", got_q.size(), 1);
        check("maj_data", pop_byte(), 8'hFF);

        // Reset during DATA, then 0x7E
        got_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt;
        rx_in = 1'b0;
        repeat (3 * CPB + 50) tick();
        check("abort_busy_before_rst", rx_busy, 1);
        rst = 1'b1;
        repeat (5) tick();
        check("abort_busy_in_rst", rx_busy, 0);
        rx_in = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle(CPB);
        check("abort_busy_after", rx_busy, 0);
        check("abort_no_byte", got_q.size(), 0);
        check("abort_ferr", ferr_cnt - f0, 0);
        check("abort_ovr", ovr_cnt - o0, 0);
        send_byte(8'h7E, CPB, 1'b1, -1, 0);
        idle(50);
        check("abort_next_count", got_q.size(), 1);
        check("abort_next_data", pop_byte(), 8'h7E);

        // Baud skew: -2% (213 clocks/bit) and +2% (221 clocks/bit)
        got_q.delete();
        f0 = ferr_cnt;
        send_byte(8'hC5, 213, 1'b1, -1, 0);
        idle(100);
        send_byte(8'h3A, 213, 1'b1, -1, 0);
        idle(100);
        send_byte(8'hC5, 221, 1'b1, -1, 0);
        idle(100);
        send_byte(8'h3A, 221, 1'b1, -1, 0);
        idle(100);
        check("skew_count", got_q.size(), 4);
        check("skew_fast_0", pop_byte(), 8'hC5);
        check("skew_fast_1", pop_byte(), 8'h3A);
        check("skew_slow_0", pop_byte(), 8'hC5);
        check("skew_slow_1", pop_byte(), 8'h3A);
        check("skew_ferr", ferr_cnt - f0, 0);

        check("never_ferr_and_ovr", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
